// File: rtl/div_seq_8b.sv
// -----------------------------------------------------------------------------
// div_seq_8b -- sequential unsigned restoring divider
//
// Purpose:
//   Divides an unsigned WIDTH-bit dividend by an unsigned WIDTH-bit divisor,
//   producing one quotient bit per clock (MSB first). A division accepted at
//   edge T reports its result with a one-cycle done pulse in cycle T+WIDTH+1.
//   Division by zero yields q = all-ones, r = a and raises dz.
//
// Optional feature (macro DIV_ZERO_FAST_EN):
//   When defined, a start with b == 0 skips the iterations entirely and
//   reports the divide-by-zero result in cycle T+1 (busy never asserts).
//   When undefined, b == 0 runs the full WIDTH iterations. The restoring
//   algorithm naturally produces the same result in that case.
//
// Ports:
//   clk   in   1      clock, all state changes on the rising edge
//   rst   in   1      synchronous active-high reset, priority over start
//   start in   1      request a new division (honoured only when idle)
//   a     in   WIDTH  dividend, sampled when start is accepted
//   b     in   WIDTH  divisor, sampled when start is accepted
//   busy  out  1      high while iterations are in progress
//   done  out  1      single-cycle pulse, q/r/dz valid from this cycle
//   q     out  WIDTH  quotient (held until the next result)
//   r     out  WIDTH  remainder (held until the next result)
//   dz    out  1      divide-by-zero flag for the last result
// -----------------------------------------------------------------------------
module div_seq_8b #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           next_state_s;

    // work_r starts as the dividend; each step shifts the next dividend bit
    // out of the top and the new quotient bit into the bottom, so after
    // WIDTH steps it holds the quotient.
    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] div_r;
    logic [CW-1:0]    cnt_r;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic             dz_r;

    logic             accept_s;
    logic             fast_zero_s;
    logic             last_step_s;
    logic [WIDTH:0]   shift_s;
    logic             geq_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] work_next_s;

    // Control decode: start acceptance, zero-divisor bypass, final iteration.
    always_comb begin
        accept_s    = 1'b0;
        last_step_s = 1'b0;
        if (state_r == IDLE) begin
            accept_s = start;
        end else begin
            accept_s = 1'b0;
        end
        if (state_r == RUN) begin
            last_step_s = (cnt_r == CW'(WIDTH - 1));
        end else begin
            last_step_s = 1'b0;
        end
`ifdef DIV_ZERO_FAST_EN
        fast_zero_s = accept_s && (b == {WIDTH{1'b0}});
`else
        fast_zero_s = 1'b0;
`endif
    end

    // One restoring step: the shifted partial remainder needs WIDTH+1 bits,
    // but after a conditional subtract it always fits back into WIDTH bits.
    always_comb begin
        shift_s     = {rem_r, work_r[WIDTH-1]};
        geq_s       = 1'b0;
        rem_next_s  = shift_s[WIDTH-1:0];
        if (shift_s >= {1'b0, div_r}) begin
            geq_s      = 1'b1;
            rem_next_s = shift_s[WIDTH-1:0] - div_r;
        end else begin
            geq_s      = 1'b0;
            rem_next_s = shift_s[WIDTH-1:0];
        end
        work_next_s = {work_r[WIDTH-2:0], geq_s};
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (fast_zero_s) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = RUN;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_step_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath, iteration counter and registered outputs. busy/done are
    // registered from the next state so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_r <= {WIDTH{1'b0}};
            rem_r  <= {WIDTH{1'b0}};
            div_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            q_r    <= {WIDTH{1'b0}};
            r_r    <= {WIDTH{1'b0}};
            dz_r   <= 1'b0;
        end else begin
            busy_r <= (next_state_s == RUN);
            done_r <= (next_state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        work_r <= a;
                        div_r  <= b;
                        rem_r  <= {WIDTH{1'b0}};
                        cnt_r  <= {CW{1'b0}};
                        if (fast_zero_s) begin
                            q_r  <= {WIDTH{1'b1}};
                            r_r  <= a;
                            dz_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    work_r <= work_next_s;
                    rem_r  <= rem_next_s;
                    cnt_r  <= cnt_r + CW'(1);
                    if (last_step_s) begin
                        q_r  <= work_next_s;
                        r_r  <= rem_next_s;
                        dz_r <= (div_r == {WIDTH{1'b0}});
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign q    = q_r;
    assign r    = r_r;
    assign dz   = dz_r;

endmodule
